// File: rtl/ahb_decoder_mux_n.sv
// AHB-Lite single-master decoder/return mux for NSLV slaves with an internal ERROR default slave.
// Optional stall timeout is enabled by defining AHB_STALL_TIMEOUT_EN.
module ahb_decoder_mux_n #(
    parameter int NSLV = 3,
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NSLV*AW-1:0] SLV_MASK = {3{32'hFFFF_0000}},
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [AW-1:0]      M_HADDR,
    input  logic [1:0]         M_HTRANS,
    input  logic [2:0]         M_HBURST,
    input  logic [2:0]         M_HSIZE,
    input  logic               M_HWRITE,
    input  logic [DW-1:0]      M_HWDATA,
    output logic [DW-1:0]      M_HRDATA,
    output logic               M_HREADY,
    output logic               M_HRESP,
    output logic [NSLV-1:0]    HSEL,
    output logic [AW-1:0]      S_HADDR,
    output logic [1:0]         S_HTRANS,
    output logic [2:0]         S_HBURST,
    output logic [2:0]         S_HSIZE,
    output logic               S_HWRITE,
    output logic [DW-1:0]      S_HWDATA,
    output logic               S_HREADY,
    input  logic [NSLV*DW-1:0] S_HRDATA,
    input  logic [NSLV-1:0]    S_HREADYOUT,
    input  logic [NSLV-1:0]    S_HRESP,
    output logic               TIMEOUT_FLAG
);

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

    logic [NSLV-1:0] hsel_c;
    logic            hit;
    logic [NSLV:0]   dsel;      // bit NSLV selects the default slave
    ds_state_t       ds_state;
    logic            ds_ready;
    logic            ds_resp;
    logic [DW-1:0]   sel_rdata;
    logic            sel_ready;
    logic            sel_resp;
    logic            ds_start;
    logic            to_fire;

    assign S_HADDR  = M_HADDR;
    assign S_HTRANS = M_HTRANS;
    assign S_HBURST = M_HBURST;
    assign S_HSIZE  = M_HSIZE;
    assign S_HWRITE = M_HWRITE;
    assign S_HWDATA = M_HWDATA;
    assign S_HREADY = M_HREADY;
    assign HSEL     = hsel_c;

    // Priority decode: lowest matching index wins, so overlapping maps stay one-hot.
    always_comb begin
        hsel_c = '0;
        hit    = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (!hit && ((M_HADDR & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
                hsel_c[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        sel_ready = ds_ready;
        sel_resp  = ds_resp;
        for (int i = 0; i < NSLV; i++) begin
            if (dsel[i]) begin
                sel_rdata = S_HRDATA[i*DW +: DW];
                sel_ready = S_HREADYOUT[i];
                sel_resp  = S_HRESP[i];
            end
        end
    end

    assign M_HRDATA = sel_rdata;
    assign M_HREADY = sel_ready;
    assign M_HRESP  = sel_resp;
    assign ds_start = ~hit & M_HTRANS[1];

`ifdef AHB_STALL_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;
    logic          slv_stall;
    logic          flag_q;

    assign slv_stall    = ~dsel[NSLV] & ~sel_ready;
    assign to_fire      = slv_stall && (cnt == CNT_LAST);
    assign TIMEOUT_FLAG = flag_q;

    // dsel only moves on HREADY=1 edges (stall ends) or on a fire, so both clear the count.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt    <= '0;
            flag_q <= 1'b0;
        end else begin
            if (!slv_stall || to_fire)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (to_fire)
                flag_q <= 1'b1;
        end
    end
`else
    assign to_fire      = 1'b0;
    assign TIMEOUT_FLAG = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            dsel <= {1'b1, {NSLV{1'b0}}};
        else if (to_fire)
            dsel <= {1'b1, {NSLV{1'b0}}};
        else if (M_HREADY)
            dsel <= {~hit, hsel_c};
    end

    // A timeout hands the data phase to the default slave, which then issues the two-cycle ERROR.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ds_state <= DS_IDLE;
            ds_ready <= 1'b1;
            ds_resp  <= 1'b0;
        end else if (to_fire || (M_HREADY && ds_start)) begin
            ds_state <= DS_ERR1;
            ds_ready <= 1'b0;
            ds_resp  <= 1'b1;
        end else if (ds_state == DS_ERR1) begin
            ds_state <= DS_ERR2;
            ds_ready <= 1'b1;
            ds_resp  <= 1'b1;
        end else begin
            ds_state <= DS_IDLE;
            ds_ready <= 1'b1;
            ds_resp  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ahb_decoder_mux_n.sv
// Directed-vector scoreboard bench for ahb_decoder_mux_n; a second instance checks an overlapping map.
module tb_ahb_decoder_mux_n;

    typedef struct {
        logic [2:0]  hsel;
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
        logic        flag;
        logic        ovl_en;
        logic [2:0]  ovl_hsel;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] m_haddr = '0;
    logic [1:0]  m_htrans = 2'b00;
    logic [2:0]  m_hburst = 3'b000;
    logic [2:0]  m_hsize = 3'b010;
    logic        m_hwrite = 1'b0;
    logic [31:0] m_hwdata = '0;
    logic [31:0] m_hrdata;
    logic        m_hready, m_hresp, s_hready, s_hwrite, tflag;
    logic [2:0]  hsel, s_hburst, s_hsize;
    logic [1:0]  s_htrans;
    logic [31:0] s_haddr, s_hwdata;
    logic [95:0] s_hrdata = {32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    logic [2:0]  s_hreadyout = 3'b111;
    logic [2:0]  s_hresp = 3'b000;

    logic [31:0] o_hrdata, o_haddr, o_hwdata;
    logic        o_hready, o_hresp, o_shready, o_hwrite, o_flag;
    logic [2:0]  o_hsel, o_hburst, o_hsize;
    logic [1:0]  o_htrans;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 HCLK = ~HCLK;

    ahb_decoder_mux_n u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M_HADDR(m_haddr), .M_HTRANS(m_htrans), .M_HBURST(m_hburst), .M_HSIZE(m_hsize),
        .M_HWRITE(m_hwrite), .M_HWDATA(m_hwdata), .M_HRDATA(m_hrdata), .M_HREADY(m_hready),
        .M_HRESP(m_hresp), .HSEL(hsel), .S_HADDR(s_haddr), .S_HTRANS(s_htrans),
        .S_HBURST(s_hburst), .S_HSIZE(s_hsize), .S_HWRITE(s_hwrite), .S_HWDATA(s_hwdata),
        .S_HREADY(s_hready), .S_HRDATA(s_hrdata), .S_HREADYOUT(s_hreadyout),
        .S_HRESP(s_hresp), .TIMEOUT_FLAG(tflag)
    );

    // Slave 1 overlaps slave 0's region; slave 0 must win.
    ahb_decoder_mux_n #(
        .SLV_BASE({32'h0002_0000, 32'h0000_0000, 32'h0000_0000}),
        .SLV_MASK({32'hFFFF_0000, 32'hFFF0_0000, 32'hFFFF_0000})
    ) u_ovl (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M_HADDR(m_haddr), .M_HTRANS(m_htrans), .M_HBURST(m_hburst), .M_HSIZE(m_hsize),
        .M_HWRITE(m_hwrite), .M_HWDATA(m_hwdata), .M_HRDATA(o_hrdata), .M_HREADY(o_hready),
        .M_HRESP(o_hresp), .HSEL(o_hsel), .S_HADDR(o_haddr), .S_HTRANS(o_htrans),
        .S_HBURST(o_hburst), .S_HSIZE(o_hsize), .S_HWRITE(o_hwrite), .S_HWDATA(o_hwdata),
        .S_HREADY(o_shready), .S_HRDATA(s_hrdata), .S_HREADYOUT(s_hreadyout),
        .S_HRESP(s_hresp), .TIMEOUT_FLAG(o_flag)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // One bus cycle: drive master/slave inputs, queue what the DUT must show during it.
    task automatic cyc(input logic rst, input logic [31:0] a, input logic [1:0] t,
                       input logic w, input logic [2:0] r, input logic [2:0] e,
                       input logic [2:0] xh, input logic xr, input logic xe,
                       input logic [31:0] xd, input logic xf, input logic [3:0] xo);
        exp_t x;
        @(posedge HCLK);
        #1;
        HRESETn     = rst;
        m_haddr     = a;
        m_htrans    = t;
        m_hwrite    = w;
        m_hwdata    = a ^ 32'h5A5A_5A5A;
        s_hreadyout = r;
        s_hresp     = e;
        x.hsel = xh; x.rdy = xr; x.resp = xe; x.rdata = xd; x.flag = xf;
        x.ovl_en = xo[3]; x.ovl_hsel = xo[2:0];
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge HCLK);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("hsel",   {29'd0, hsel},     {29'd0, x.hsel});
                chk("hready", {31'd0, m_hready}, {31'd0, x.rdy});
                chk("hresp",  {31'd0, m_hresp},  {31'd0, x.resp});
                chk("hrdata", m_hrdata,          x.rdata);
                chk("tflag",  {31'd0, tflag},    {31'd0, x.flag});
                if (x.ovl_en)
                    chk("ovl_hsel", {29'd0, o_hsel}, {29'd0, x.ovl_hsel});
            end
        end
    end

    localparam logic [1:0] ID = 2'b00, NS = 2'b10;
    localparam logic [31:0] D0 = 32'hCAFE_0000, D1 = 32'hCAFE_0001, D2 = 32'hCAFE_0002;
    localparam logic [31:0] UA = 32'h0005_0000;

    initial begin : stim
        // reset
        cyc(0, 32'h0,          ID, 0, 3'b111, 3'b000, 3'b001, 1, 0, 0,  0, 4'b0000);
        cyc(0, 32'h0,          ID, 0, 3'b111, 3'b000, 3'b001, 1, 0, 0,  0, 4'b0000);
        // overlap map: 0x1000 hits S0 on both instances
        cyc(1, 32'h0000_1000,  ID, 0, 3'b111, 3'b000, 3'b001, 1, 0, 0,  0, 4'b1001);
        // S1 read with one wait state
        cyc(1, 32'h0001_0010,  NS, 0, 3'b111, 3'b000, 3'b010, 1, 0, D0, 0, 4'b1010);
        cyc(1, 32'h0,          ID, 0, 3'b101, 3'b000, 3'b001, 0, 0, D1, 0, 4'b0000);
        cyc(1, 32'h0,          ID, 0, 3'b111, 3'b000, 3'b001, 1, 0, D1, 0, 4'b0000);
        // back-to-back S0 (2 waits) then S2
        cyc(1, 32'h0000_0004,  NS, 0, 3'b111, 3'b000, 3'b001, 1, 0, D0, 0, 4'b0000);
        cyc(1, 32'h0002_0008,  NS, 0, 3'b110, 3'b000, 3'b100, 0, 0, D0, 0, 4'b0000);
        cyc(1, 32'h0002_0008,  NS, 0, 3'b110, 3'b000, 3'b100, 0, 0, D0, 0, 4'b0000);
        cyc(1, 32'h0002_0008,  NS, 0, 3'b111, 3'b000, 3'b100, 1, 0, D0, 0, 4'b0000);
        // unmapped IDLE gets OKAY; unmapped NONSEQ write gets two-cycle ERROR
        cyc(1, UA,             ID, 0, 3'b111, 3'b000, 3'b000, 1, 0, D2, 0, 4'b0000);
        cyc(1, UA,             NS, 1, 3'b111, 3'b000, 3'b000, 1, 0, 0,  0, 4'b1010);
        cyc(1, UA,             ID, 0, 3'b111, 3'b000, 3'b000, 0, 1, 0,  0, 4'b0000);
        cyc(1, UA,             ID, 0, 3'b111, 3'b000, 3'b000, 1, 1, 0,  0, 4'b0000);
        cyc(1, UA,             ID, 0, 3'b111, 3'b000, 3'b000, 1, 0, 0,  0, 4'b0000);
        // back-to-back unmapped: ERR2 -> ERR1
        cyc(1, UA,             NS, 0, 3'b111, 3'b000, 3'b000, 1, 0, 0,  0, 4'b0000);
        cyc(1, UA,             NS, 0, 3'b111, 3'b000, 3'b000, 0, 1, 0,  0, 4'b0000);
        cyc(1, UA,             NS, 0, 3'b111, 3'b000, 3'b000, 1, 1, 0,  0, 4'b0000);
        cyc(1, UA,             ID, 0, 3'b111, 3'b000, 3'b000, 0, 1, 0,  0, 4'b0000);
        cyc(1, UA,             ID, 0, 3'b111, 3'b000, 3'b000, 1, 1, 0,  0, 4'b0000);
        cyc(1, UA,             ID, 0, 3'b111, 3'b000, 3'b000, 1, 0, 0,  0, 4'b0000);
        // slave ERROR response passes through
        cyc(1, 32'h0001_0000,  NS, 0, 3'b111, 3'b000, 3'b010, 1, 0, 0,  0, 4'b0000);
        cyc(1, UA,             ID, 0, 3'b101, 3'b010, 3'b000, 0, 1, D1, 0, 4'b0000);
        cyc(1, UA,             ID, 0, 3'b111, 3'b010, 3'b000, 1, 1, D1, 0, 4'b0000);
        cyc(1, UA,             ID, 0, 3'b111, 3'b000, 3'b000, 1, 0, 0,  0, 4'b0000);
        // reset during a stalled S2 data phase
        cyc(1, 32'h0002_0000,  NS, 0, 3'b111, 3'b000, 3'b100, 1, 0, 0,  0, 4'b0000);
        cyc(1, 32'h0,          ID, 0, 3'b011, 3'b000, 3'b001, 0, 0, D2, 0, 4'b0000);
        cyc(0, 32'h0,          ID, 0, 3'b011, 3'b000, 3'b001, 1, 0, 0,  0, 4'b0000);
        cyc(1, 32'h0,          ID, 0, 3'b011, 3'b000, 3'b001, 1, 0, 0,  0, 4'b0000);
        // long S2 stall
        cyc(1, 32'h0002_0000,  NS, 0, 3'b111, 3'b000, 3'b100, 1, 0, D0, 0, 4'b0000);
`ifdef AHB_STALL_TIMEOUT_EN
        for (int i = 0; i < 16; i++)
            cyc(1, 32'h0,      ID, 0, 3'b011, 3'b000, 3'b001, 0, 0, D2, 0, 4'b0000);
        cyc(1, 32'h0,          ID, 0, 3'b011, 3'b000, 3'b001, 0, 1, 0,  1, 4'b0000);
        cyc(1, 32'h0,          ID, 0, 3'b011, 3'b000, 3'b001, 1, 1, 0,  1, 4'b0000);
        cyc(1, 32'h0000_0004,  NS, 0, 3'b011, 3'b000, 3'b001, 1, 0, D0, 1, 4'b0000);
        cyc(1, 32'h0,          ID, 0, 3'b011, 3'b000, 3'b001, 1, 0, D0, 1, 4'b0000);
`else
        for (int i = 0; i < 20; i++)
            cyc(1, 32'h0,      ID, 0, 3'b011, 3'b000, 3'b001, 0, 0, D2, 0, 4'b0000);
        cyc(1, 32'h0,          ID, 0, 3'b111, 3'b000, 3'b001, 1, 0, D2, 0, 4'b0000);
        cyc(1, 32'h0000_0004,  NS, 0, 3'b111, 3'b000, 3'b001, 1, 0, D0, 0, 4'b0000);
        cyc(1, 32'h0,          ID, 0, 3'b111, 3'b000, 3'b001, 1, 0, D0, 0, 4'b0000);
`endif
        repeat (3) @(negedge HCLK);
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ahb_decoder_mux_n.md
Name: ahb_decoder_mux_n

Overview:
Parametrised single-master AHB-Lite interconnect for NSLV slaves with a programmable base/mask address map. The decoder drives address-phase HSEL, and a registered data-phase select steers HRDATA/HREADYOUT/HRESP back to the master. An internal default slave returns the two-cycle AHB ERROR response for unmapped active transfers. Sits between the single bus master and the peripheral slaves.

Parameters:
NSLV, 3, number of slaves (1..16)
AW, 32, address width
DW, 32, data width
SLV_BASE, {32'h0002_0000,32'h0001_0000,32'h0000_0000}, packed NSLV*AW base addresses, slave i at [i*AW +: AW]
SLV_MASK, {3{32'hFFFF_0000}}, packed NSLV*AW decode masks
TIMEOUT_CYC, 16, stall limit in cycles (used only with the optional feature; >=2)

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
M_HADDR  in  AW  master address
M_HTRANS  in  2  master transfer type
M_HBURST  in  3  burst type
M_HSIZE  in  3  transfer size
M_HWRITE  in  1  write flag
M_HWDATA  in  DW  write data
M_HRDATA  out  DW  muxed read data
M_HREADY  out  1  muxed ready, also broadcast to slaves
M_HRESP  out  1  muxed response (0 OKAY, 1 ERROR)
HSEL  out  NSLV  one-hot address-phase slave select
S_HADDR/S_HTRANS/S_HBURST/S_HSIZE/S_HWRITE/S_HWDATA  out  AW/2/3/3/1/DW  shared copies of master signals
S_HREADY  out  1  equals M_HREADY
S_HRDATA  in  NSLV*DW  packed slave read data
S_HREADYOUT  in  NSLV  slave ready outputs
S_HRESP  in  NSLV  slave responses
TIMEOUT_FLAG  out  1  sticky stall-timeout indication (tied 0 when feature disabled)

Behaviour:
- Reset HRESETn is asynchronous, active-low; clock is HCLK. All state is reset asynchronously.
- Decode (combinational): slave i matches when (M_HADDR & MASK_i) == BASE_i. The lowest matching index wins. HSEL is one-hot or all-zero, and is not gated by HTRANS; slaves qualify it with HTRANS and HREADY.
- Data-phase select dsel (NSLV+1 one-hot, extra bit = default slave) is registered on posedge HCLK only when M_HREADY=1. Otherwise it holds.
- Reset state: dsel = default slave, default-slave FSM in DS_IDLE. This gives M_HREADY=1, M_HRESP=0, M_HRDATA=0.
- Return mux: if dsel selects slave i, then M_HRDATA = S_HRDATA[i], M_HREADY = S_HREADYOUT[i], M_HRESP = S_HRESP[i]. If dsel selects the default slave, outputs come from the default FSM and M_HRDATA = 0.
- Default slave FSM (states DS_IDLE, DS_ERR1, DS_ERR2):
  - DS_IDLE: HREADYOUT=1, HRESP=0. Moves to DS_ERR1 when M_HREADY=1, no slave matches, and M_HTRANS[1]=1 (NONSEQ/SEQ).
  - DS_ERR1: HREADYOUT=0, HRESP=1. Always moves to DS_ERR2.
  - DS_ERR2: HREADYOUT=1, HRESP=1. Goes to DS_ERR1 if a new unmapped active transfer is accepted this cycle, else DS_IDLE.
  - Unmapped IDLE/BUSY transfers get a zero-wait OKAY.
- Latency: zero added cycles. The data phase completes in the same cycle the selected HREADYOUT=1.
- Back-to-back transfers to different slaves: the address phase of slave j overlaps the data phase of slave i. dsel switches only at the HREADY=1 edge.
- Master dropping the burst after ERR1 (HTRANS=IDLE in ERR2): no further error.
- Reset mid-transfer: dsel and FSM return to the reset state immediately. Slave outputs are ignored until the next accepted address phase.

Optional Feature:
Macro AHB_STALL_TIMEOUT_EN.
- Defined: a counter counts consecutive cycles with dsel on a real slave and that slave's HREADYOUT=0.
  - When the count reaches TIMEOUT_CYC, the interconnect forces a two-cycle ERROR to the master (cycle 1: M_HREADY=0, M_HRESP=1; cycle 2: M_HREADY=1, M_HRESP=1). It then sets dsel to the default slave and sets TIMEOUT_FLAG.
  - The stalled slave's outputs are ignored from that point.
  - TIMEOUT_FLAG clears only on reset.
  - The counter clears whenever the selected HREADYOUT=1 or dsel changes.
- Not defined: no counter; TIMEOUT_FLAG is tied to 0; a slave may stall indefinitely.

Test Plan:
- Reset: HRESETn=0 -> M_HREADY=1, M_HRESP=0, M_HRDATA=0, TIMEOUT_FLAG=0. Release -> idle OKAY.
- NONSEQ read 0x0001_0010 -> HSEL=3'b010 in the address phase; data phase returns S1 HRDATA 0xCAFE_0001 with S1 wait states propagated to M_HREADY.
- Back-to-back reads at 0x0000_0004 then 0x0002_0008, S0 inserting 2 waits -> M_HRDATA=S0 data when S0 ready, then S2 data next. dsel never switches while M_HREADY=0.
- NONSEQ write to 0x0005_0000 -> cycle1 M_HREADY=0/M_HRESP=1, cycle2 M_HREADY=1/M_HRESP=1. IDLE to the same address -> OKAY, zero waits.
- Overlapping map: SLV_BASE1=0x0000_0000, MASK1=0xFFF0_0000, access 0x0000_1000 -> lowest index S0 selected.
- With AHB_STALL_TIMEOUT_EN, TIMEOUT_CYC=16, S2 holds HREADYOUT=0 -> after 16 stall cycles, two-cycle ERROR and TIMEOUT_FLAG=1. The next access to S0 completes normally.
